// File: rtl/sprite_rom_reader.sv
// Streams ROM_SIZE words from a synchronous-read ROM into a 2-entry output FIFO with valid/ready.
// Define SPRITE_ROM_READER_LOOP_EN to make the read pass wrap and repeat forever.
module sprite_rom_reader #(
   parameter int unsigned DATA_WIDTH = 12,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned ROM_SIZE   = 220
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROM_SIZE - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  inflight_q, inflight_d;
   logic [1:0]            count_q, count_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic [DATA_WIDTH-1:0] mem_q [2];
   logic                  pop;
   logic                  push;
   logic                  issue;
   logic [2:0]            occ;

   assign pop      = m_valid & m_ready;
   // Issue rule keeps count+inflight <= 2, so a returning word always finds a free slot.
   assign push     = inflight_q;
   assign occ      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign m_valid  = (count_q != 2'd0);
   assign m_data   = mem_q[rd_ptr_q];
   assign rom_addr = addr_q;
   assign busy     = (state_q != IDLE);

`ifdef SPRITE_ROM_READER_LOOP_EN
   logic [ADDR_WIDTH-1:0] out_idx_q, out_idx_d;

   always_comb begin
      out_idx_d = out_idx_q;
      if (pop) begin
         out_idx_d = (out_idx_q == LAST_ADDR) ? '0 : out_idx_q + ADDR_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_idx_q <= '0;
      end else begin
         out_idx_q <= out_idx_d;
      end
   end
`endif

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      issue      = 1'b0;
      done       = 1'b0;
      inflight_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = READ;
               addr_d  = '0;
            end
         end
         READ: begin
            issue      = (occ < 3'd2);
            inflight_d = issue;
            if (issue) begin
               if (addr_q == LAST_ADDR) begin
`ifdef SPRITE_ROM_READER_LOOP_EN
                  addr_d  = '0;
`else
                  addr_d  = addr_q + ADDR_ONE;
                  state_d = DRAIN;
`endif
               end else begin
                  addr_d = addr_q + ADDR_ONE;
               end
            end
         end
         DRAIN: begin
            if ((count_q == 2'd0) && !inflight_q) begin
               state_d = IDLE;
               done    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef SPRITE_ROM_READER_LOOP_EN
      done = pop && (out_idx_q == LAST_ADDR);
`endif
   end

   always_comb begin
      count_d  = count_q + {1'b0, push} - {1'b0, pop};
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         inflight_q <= 1'b0;
         count_q    <= 2'd0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         if (push) begin
            mem_q[wr_ptr_q] <= rom_data;
         end
      end
   end

endmodule

// File: doc/sprite_rom_reader.md
SPRITE_ROM_READER -- requirements
Module: sprite_rom_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 12, sets the width of the ROM word and the stream word (RGB444 pixel).
REQ-002 Parameter ADDR_WIDTH, default 8, sets the ROM address width.
REQ-003 Parameter ROM_SIZE, default 220, sets the number of words read per pass.
REQ-004 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  is the reset: asynchronous, active-high.
REQ-006 Port start  input  1  is a single-cycle pass request.
REQ-007 Port rom_addr  output  ADDR_WIDTH  is the address driven to the synchronous-read ROM.
REQ-008 Port rom_data  input  DATA_WIDTH  is the ROM output, valid one cycle after its address is presented.
REQ-009 Port m_data  output  DATA_WIDTH  is the stream word.
REQ-010 Port m_valid  output  1  flags m_data as valid.
REQ-011 Port m_ready  input  1  is downstream acceptance; a transfer occurs when m_valid and m_ready are both 1.
REQ-012 Port busy  output  1  is high while a pass is in progress.
REQ-013 Port done  output  1  is a one-cycle pulse at pass completion.

Function
REQ-014 FSM states: IDLE, READ, DRAIN.
- IDLE -> READ on start=1; address counter loads 0.
- READ -> DRAIN once address ROM_SIZE-1 is issued.
- DRAIN -> IDLE when the FIFO is empty and no read is in flight; done=1 for that cycle.
REQ-015 start is ignored outside IDLE.
REQ-016 rom_addr equals the address counter register at all times.
REQ-017 Issue rule: in READ, a read issues in cycle N when (fifo_count + inflight - pop) < 2, where pop = m_valid & m_ready.
- On issue, the counter increments at the end of cycle N.
REQ-018 The read issued in cycle N returns on rom_data in cycle N+1.
- It is written into the FIFO at the end of cycle N+1.
- inflight is a 1-bit register set by issue.
REQ-019 The output FIFO holds 2 entries.
- m_valid = (fifo_count != 0).
- m_data is the head entry.
- Words are delivered in address order 0..ROM_SIZE-1, none dropped or duplicated.
REQ-020 A simultaneous FIFO write and pop on a full or one-entry FIFO leaves fifo_count unchanged and keeps ordering.
REQ-021 fifo_count never exceeds 2, even with m_ready held 0 indefinitely.
REQ-022 Latency: start in cycle 0 gives m_valid=1 with ROM[0] in cycle 3.
REQ-023 Throughput: with m_ready held 1, one word transfers per cycle.
REQ-024 busy = (state != IDLE).
REQ-025 m_data holds its value while m_valid=1 and m_ready=0.

Reset
REQ-026 While reset=1, outputs take these values asynchronously:
- state=IDLE; counter=0, so rom_addr=0.
- inflight=0; fifo_count=0, so m_valid=0.
- m_data=0, busy=0, done=0.
REQ-027 Reset mid-pass aborts the pass.
- A ROM word returning in the cycle after reset is discarded.
- No done pulse is produced.

Configuration
REQ-028 Macro SPRITE_ROM_READER_LOOP_EN selects looping.
- Defined: in READ, after issuing ROM_SIZE-1 the counter wraps to 0 and READ continues; DRAIN is never entered.
- Defined: done pulses in the cycle the word from address ROM_SIZE-1 transfers, and busy stays 1 until reset.
- Undefined: single-pass behaviour per REQ-014.

Verification
REQ-029 Scenario basic pass:
- Stimulus: start in cycle 0, m_ready=1, ROM[i]=i+0x100.
- Response: m_valid in cycles 3..222 carries 0x100..0x1DB; done in cycle 223; busy=0 from cycle 224.
REQ-030 Scenario backpressure:
- Stimulus: m_ready=0 for cycles 0..20 after start.
- Response: fifo_count stays at 2, rom_addr stays at 2, m_data=ROM[0] stable.
- Release: words 0,1,2 follow on consecutive cycles.
REQ-031 Scenario random m_ready (50%):
- Response: all 220 words arrive in order with no duplicates; done fires exactly once after the last transfer.
REQ-032 Scenario start ignored:
- Stimulus: start pulsed in cycle 50 of a pass.
- Response: no restart; the sequence is unchanged.
REQ-033 Scenario mid-pass reset:
- Stimulus: reset asserted in cycle 100.
- Response: m_valid=0 and busy=0 immediately; no done pulse; a new start gives ROM[0] three cycles later.
REQ-034 Scenario SPRITE_ROM_READER_LOOP_EN defined:
- Response: the word after ROM[219] is ROM[0]; done pulses every 220 transfers; busy stays 1.
